cpu_phase_gen: RTL and testbench
================================

Name: cpu_phase_gen

Overview:
- Timing generator that sits directly upstream of the multi-cycle CPU top and drives its one-hot phase bus `p`.
- Phase order: IF, ID, EX, MEM, WB.
- Sequences the phases, holds on stall, and supports early termination when the control unit finishes an instruction before WB.
- Handles run/halt control, a sticky fault stop on an ALU error, and cycle/instruction counters for the debug console.

Parameters:
NPHASE, 5, number of phases; width of p; last phase is p[NPHASE-1]
CNT_W, 32, width of cycle and retired-instruction counters

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = execute, 0 = stop at next instruction boundary
halt_req  input  1  single-cycle pulse; request stop at next instruction boundary
step_req  input  1  single-cycle pulse; execute exactly one instruction from HALT (STEP_EN only)
stall  input  1  hold current phase (memory wait)
instr_done  input  1  CU indicates current phase is the final phase of this instruction
err  input  1  ALU/CU error; forces fault stop
p  output  NPHASE  one-hot phase to the CPU; all-zero when not executing
running  output  1  1 in RUN state
halted  output  1  1 in HALT state
fault  output  1  1 in FAULT state (sticky until reset)
cyc_cnt  output  CNT_W  cycles spent in RUN, including stalled cycles
instr_cnt  output  CNT_W  retired instructions

Behaviour:
- States: IDLE, RUN, HALT, FAULT. Registered outputs only.
- Reset (any state, mid-instruction included) clears everything at the next edge:
  - state = IDLE, p = 0, running = halted = fault = 0.
  - cyc_cnt = instr_cnt = 0; the pending halt flag is cleared.
- IDLE or HALT with run=1 and no pending halt:
  - Next cycle state = RUN, p = 1 (IF).
  - Entering RUN clears the pending halt flag.
- RUN, each cycle (priority top to bottom):
  1. err=1: state = FAULT, p = 0, fault = 1. The current instruction is not retired.
  2. stall=1: p holds; no retire, even if instr_done=1 or p is in the last phase.
  3. Boundary (instr_done=1 or p[NPHASE-1]=1): instr_cnt += 1.
     - If halt pending, halt_req=1 this cycle, or run=0: state = HALT, p = 0, halted = 1.
     - Otherwise p = 1, so the next instruction starts with no bubble.
  4. Otherwise p shifts left by one.
- cyc_cnt increments on every RUN cycle, stalled or not. It holds in IDLE, HALT and FAULT.
- halt_req arriving mid-instruction is latched as pending. It is honoured at the boundary and never truncates an instruction.
- halt_req in IDLE or HALT sets pending, which blocks a restart. Pending clears when run is deasserted.
- FAULT: p = 0. Ignores run, halt_req and step_req. Leaves only via reset.
- Counters wrap from 2^CNT_W-1 to 0 silently.
- p is always one-hot or zero; no other encoding is ever produced.

Optional Feature:
Macro `CPU_PHASE_STEP_EN`.
- Defined:
  - In HALT, a step_req pulse starts one instruction (p = 1 next cycle, running = 1).
  - At that instruction's boundary, state returns to HALT regardless of run.
  - step_req is ignored in RUN, IDLE and FAULT.
  - If run=1 at the step boundary, the next cycle restarts RUN normally.
- Undefined: step_req is ignored entirely; the port remains present.

Test Plan:
1. Reset, run=1 held, instr_done=0: p cycles 00001,00010,00100,01000,10000,00001; instr_cnt=1 after the first WB; cyc_cnt=5 after 5 RUN cycles.
2. instr_done=1 during EX (p=00100): next p=00001; instr_cnt increments by 1.
3. stall=1 for 3 cycles at p=01000 with instr_done=1: p holds 01000 for 3 cycles, no retire; after release, retire and p=00001; cyc_cnt includes the 3 stall cycles.
4. halt_req pulse at ID: instruction completes through WB, then p=00000 and halted=1; instr_cnt increments exactly once; cyc_cnt frozen.
5. err=1 at MEM: next p=00000, fault=1, instr_cnt unchanged; run toggling has no effect; reset returns to IDLE with counters 0.
6. `CPU_PHASE_STEP_EN` defined, HALT state, run=0, step_req pulse: exactly 5 phases then HALT, instr_cnt +1. Macro undefined: same stimulus leaves p=00000.

Source files
------------

// File: rtl/cpu_phase_gen.sv
// cpu_phase_gen
//   Phase timing generator for the multi-cycle CPU. Drives a one-hot phase
//   bus (IF, ID, EX, MEM, WB for NPHASE=5) and sequences it through run,
//   halt, single-step and fault-stop control. It also keeps cycle and
//   retired-instruction counters for the debug console.
//
// Optional build macro: CPU_PHASE_STEP_EN
//   When defined, a step_req pulse in HALT executes exactly one instruction.
//   When undefined, step_req is ignored but the port is kept.
//
// Ports
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   run        in   level: 1 = execute, 0 = stop at next instruction boundary
//   halt_req   in   pulse: stop at next instruction boundary
//   step_req   in   pulse: execute one instruction from HALT (step build only)
//   stall      in   hold the current phase (memory wait)
//   instr_done in   current phase is the final phase of this instruction
//   err        in   ALU/CU error; forces a sticky fault stop
//   p          out  one-hot phase, all-zero when not executing
//   running    out  1 in RUN
//   halted     out  1 in HALT
//   fault      out  1 in FAULT (sticky until reset)
//   cyc_cnt    out  cycles spent in RUN, including stalled cycles
//   instr_cnt  out  retired instructions
module cpu_phase_gen #(
  parameter int unsigned NPHASE = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              stall,
  input  logic              instr_done,
  input  logic              err,
  output logic [NPHASE-1:0] p,
  output logic              running,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [NPHASE-1:0] P_FIRST = {{(NPHASE-1){1'b0}}, 1'b1};

`ifdef CPU_PHASE_STEP_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif

  state_t              r_state;
  logic                r_pend;   // halt requested, not yet honoured
  logic                r_step;   // current instruction was started by a step

  state_t              w_state_nxt;
  logic [NPHASE-1:0]   w_p_nxt;
  logic                w_pend_nxt;
  logic                w_step_nxt;
  logic [CNT_W-1:0]    w_cyc_nxt;
  logic [CNT_W-1:0]    w_icnt_nxt;
  logic                w_boundary;
  logic                w_stop_at_boundary;
  logic                w_step_go;

  assign w_step_go          = STEP_EN & step_req;
  assign w_boundary         = instr_done | p[NPHASE-1];
  assign w_stop_at_boundary = r_pend | halt_req | ~run | r_step;

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = p;
    // A halt request is remembered until RUN is entered or run is dropped;
    // while remembered it blocks an automatic restart from IDLE/HALT.
    w_pend_nxt  = halt_req | (r_pend & run);
    w_step_nxt  = r_step;
    w_cyc_nxt   = cyc_cnt;
    w_icnt_nxt  = instr_cnt;

    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (run && !r_pend && !halt_req) begin
          w_state_nxt = S_RUN;
          w_p_nxt     = P_FIRST;
          w_pend_nxt  = 1'b0;
          w_step_nxt  = 1'b0;
        end else if (r_state == S_HALT && w_step_go) begin
          w_state_nxt = S_RUN;
          w_p_nxt     = P_FIRST;
          w_pend_nxt  = 1'b0;
          w_step_nxt  = 1'b1;
        end
      end

      S_RUN: begin
        w_cyc_nxt = cyc_cnt + CNT_W'(1);
        if (err) begin
          w_state_nxt = S_FAULT;
          w_p_nxt     = '0;
          w_pend_nxt  = 1'b0;
          w_step_nxt  = 1'b0;
        end else if (stall) begin
          w_p_nxt = p;
        end else if (w_boundary) begin
          w_icnt_nxt = instr_cnt + CNT_W'(1);
          if (w_stop_at_boundary) begin
            w_state_nxt = S_HALT;
            w_p_nxt     = '0;
            w_step_nxt  = 1'b0;
          end else begin
            w_p_nxt = P_FIRST;
          end
        end else begin
          w_p_nxt = p << 1;
        end
      end

      S_FAULT: begin
        w_p_nxt    = '0;
        w_pend_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_p_nxt     = '0;
        w_pend_nxt  = 1'b0;
        w_step_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pend    <= 1'b0;
      r_step    <= 1'b0;
      p         <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_step    <= w_step_nxt;
      p         <= w_p_nxt;
      running   <= (w_state_nxt == S_RUN);
      halted    <= (w_state_nxt == S_HALT);
      fault     <= (w_state_nxt == S_FAULT);
      cyc_cnt   <= w_cyc_nxt;
      instr_cnt <= w_icnt_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_phase_gen.sv
module tb_cpu_phase_gen;

  localparam int unsigned NPHASE = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, run, halt_req, step_req, stall, instr_done, err;
  logic [NPHASE-1:0] p;
  logic              running, halted, fault;
  logic [CNT_W-1:0]  cyc_cnt, instr_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cyc  = 0;
  int exp_icnt = 0;

  cpu_phase_gen #(.NPHASE(NPHASE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .stall      (stall),
    .instr_done (instr_done),
    .err        (err),
    .p          (p),
    .running    (running),
    .halted     (halted),
    .fault      (fault),
    .cyc_cnt    (cyc_cnt),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    stall = 1'b0; instr_done = 1'b0; err = 1'b0;
    tick(); tick();
    checks++;
    if (p !== 5'b00000) begin failures++; $display("FAIL reset_p actual=%b required=%b", p, 5'b00000); end
    checks++;
    if ({running, halted, fault} !== 3'b000) begin failures++; $display("FAIL reset_flags actual=%b required=000", {running, halted, fault}); end
    checks++;
    if (cyc_cnt !== 4'd0 || instr_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt actual=%0d/%0d required=0/0", cyc_cnt, instr_cnt); end
    reset = 1'b0;
    tick();
    checks++;
    if (p !== 5'b00000 || running !== 1'b0) begin failures++; $display("FAIL idle_hold actual=%b/%b required=00000/0", p, running); end
  endtask

  task automatic test_sequence();
    logic [NPHASE-1:0] exp_p [5];
    exp_p[0] = 5'b00010; exp_p[1] = 5'b00100; exp_p[2] = 5'b01000;
    exp_p[3] = 5'b10000; exp_p[4] = 5'b00001;
    run = 1'b1;
    tick();
    checks++;
    if (p !== 5'b00001 || running !== 1'b1) begin failures++; $display("FAIL seq_start actual=%b/%b required=00001/1", p, running); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (p !== exp_p[i]) begin failures++; $display("FAIL seq_p%0d actual=%b required=%b", i, p, exp_p[i]); end
    end
    exp_cyc = 5; exp_icnt = 1;
    checks++;
    if (instr_cnt !== CNT_W'(exp_icnt)) begin failures++; $display("FAIL seq_icnt actual=%0d required=%0d", instr_cnt, exp_icnt); end
    checks++;
    if (cyc_cnt !== CNT_W'(exp_cyc)) begin failures++; $display("FAIL seq_cyc actual=%0d required=%0d", cyc_cnt, exp_cyc); end
  endtask

  task automatic test_early_done();
    tick(); tick();
    checks++;
    if (p !== 5'b00100) begin failures++; $display("FAIL early_ex actual=%b required=00100", p); end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    exp_cyc = 8; exp_icnt = 2;
    checks++;
    if (p !== 5'b00001) begin failures++; $display("FAIL early_p actual=%b required=00001", p); end
    checks++;
    if (instr_cnt !== CNT_W'(exp_icnt)) begin failures++; $display("FAIL early_icnt actual=%0d required=%0d", instr_cnt, exp_icnt); end
  endtask

  task automatic test_stall();
    tick(); tick(); tick();
    checks++;
    if (p !== 5'b01000) begin failures++; $display("FAIL stall_mem actual=%b required=01000", p); end
    stall = 1'b1; instr_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (p !== 5'b01000 || instr_cnt !== CNT_W'(exp_icnt)) begin
        failures++; $display("FAIL stall_hold%0d actual=%b/%0d required=01000/%0d", i, p, instr_cnt, exp_icnt);
      end
    end
    stall = 1'b0;
    tick();
    instr_done = 1'b0;
    exp_cyc = 15; exp_icnt = 3;
    checks++;
    if (p !== 5'b00001 || instr_cnt !== CNT_W'(exp_icnt)) begin failures++; $display("FAIL stall_release actual=%b/%0d required=00001/%0d", p, instr_cnt, exp_icnt); end
    checks++;
    if (cyc_cnt !== CNT_W'(exp_cyc)) begin failures++; $display("FAIL stall_cyc actual=%0d required=%0d", cyc_cnt, exp_cyc); end
  endtask

  task automatic test_halt();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (p !== 5'b00100 || running !== 1'b1) begin failures++; $display("FAIL halt_no_trunc actual=%b/%b required=00100/1", p, running); end
    tick(); tick();
    checks++;
    if (p !== 5'b10000) begin failures++; $display("FAIL halt_wb actual=%b required=10000", p); end
    tick();
    exp_cyc = 20; exp_icnt = 4;
    checks++;
    if (p !== 5'b00000 || halted !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL halt_state actual=%b/%b/%b required=00000/1/0", p, halted, running); end
    checks++;
    if (instr_cnt !== CNT_W'(exp_icnt)) begin failures++; $display("FAIL halt_icnt actual=%0d required=%0d", instr_cnt, exp_icnt); end
    tick(); tick();
    checks++;
    if (p !== 5'b00000 || halted !== 1'b1 || cyc_cnt !== CNT_W'(exp_cyc)) begin
      failures++; $display("FAIL halt_frozen actual=%b/%b/%0d required=00000/1/%0d", p, halted, cyc_cnt, exp_cyc);
    end
  endtask

  task automatic test_step();
    run = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
`ifdef CPU_PHASE_STEP_EN
    checks++;
    if (p !== 5'b00001 || running !== 1'b1) begin failures++; $display("FAIL step_start actual=%b/%b required=00001/1", p, running); end
    tick(); tick(); tick(); tick();
    checks++;
    if (p !== 5'b10000) begin failures++; $display("FAIL step_wb actual=%b required=10000", p); end
    tick();
    exp_cyc = exp_cyc + 5; exp_icnt = exp_icnt + 1;
`else
    tick(); tick();
`endif
    checks++;
    if (p !== 5'b00000 || halted !== 1'b1) begin failures++; $display("FAIL step_end actual=%b/%b required=00000/1", p, halted); end
    checks++;
    if (instr_cnt !== CNT_W'(exp_icnt) || cyc_cnt !== CNT_W'(exp_cyc)) begin
      failures++; $display("FAIL step_cnt actual=%0d/%0d required=%0d/%0d", instr_cnt, cyc_cnt, exp_icnt, exp_cyc);
    end
  endtask

  task automatic test_restart();
    run = 1'b1;
    tick();
    checks++;
    if (p !== 5'b00001 || running !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL restart actual=%b/%b/%b required=00001/1/0", p, running, halted); end
  endtask

  task automatic test_fault();
    tick(); tick(); tick();
    exp_cyc = exp_cyc + 3;
    checks++;
    if (p !== 5'b01000) begin failures++; $display("FAIL fault_mem actual=%b required=01000", p); end
    err = 1'b1;
    tick();
    err = 1'b0;
    exp_cyc = exp_cyc + 1;
    checks++;
    if (p !== 5'b00000 || fault !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL fault_entry actual=%b/%b/%b required=00000/1/0", p, fault, running); end
    checks++;
    if (instr_cnt !== CNT_W'(exp_icnt)) begin failures++; $display("FAIL fault_icnt actual=%0d required=%0d", instr_cnt, exp_icnt); end
    run = 1'b0; tick();
    run = 1'b1; tick();
    halt_req = 1'b1; step_req = 1'b1; tick();
    halt_req = 1'b0; step_req = 1'b0; tick();
    checks++;
    if (p !== 5'b00000 || fault !== 1'b1 || running !== 1'b0 || cyc_cnt !== CNT_W'(exp_cyc)) begin
      failures++; $display("FAIL fault_sticky actual=%b/%b/%b/%0d required=00000/1/0/%0d", p, fault, running, cyc_cnt, exp_cyc);
    end
    run = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (fault !== 1'b0 || p !== 5'b00000 || cyc_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
      failures++; $display("FAIL fault_reset actual=%b/%b/%0d/%0d required=0/00000/0/0", fault, p, cyc_cnt, instr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (p !== 5'b00100) begin failures++; $display("FAIL mid_ex actual=%b required=00100", p); end
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    checks++;
    if (p !== 5'b00000 || running !== 1'b0 || cyc_cnt !== 4'd0) begin failures++; $display("FAIL mid_reset actual=%b/%b/%0d required=00000/0/0", p, running, cyc_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_early_done();
    test_stall();
    test_halt();
    test_step();
    test_restart();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
